rv_uart_busmaster: RTL and testbench

//  UART-to-bus bridge. Host-side counterpart of the SoC mini UART: decodes

---
 rtl/rv_uart_busmaster.sv | 174 +++++++++++++++++
 tb/tb_rv_uart_busmaster.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv_uart_busmaster.sv
// rv_uart_busmaster: UART command frames ('W' addr data / 'R' addr) to bus writes/reads with serial replies.
// Optional inter-byte frame timeout enabled by defining RV_UBM_TIMEOUT_EN.
module rv_uart_busmaster #(
  parameter int BAUD_DIV = 10,
  parameter int TO_CYC = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  output logic        txd,
  output logic [31:0] adr,
  output logic        cs,
  output logic [3:0]  we,
  output logic        re,
  output logic [31:0] dw,
  input  logic [31:0] dr,
  input  logic        rdy,
  output logic        busy,
  output logic        ferr
);
  localparam logic [15:0] FULL = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF = 16'(BAUD_DIV / 2 - 1);
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_t;
  typedef enum logic [2:0] {P_IDLE, P_ADDR, P_DATA, P_REQ, P_WAIT, P_REPLY} ps_t;
  rx_t rx_st;
  ps_t st, st_n;
  logic [2:0] rs;
  logic [15:0] rcnt, tcnt;
  logic [2:0] nb;
  logic [7:0] rx_dat, tx_dat;
  logic rx_vld, tx_ld, tx_busy, is_w, cap, tout;
  logic [8:0] tsh;
  logic [3:0] tbc;
  logic [1:0] cnt;
  logic [31:0] abuf, rsh;
  assign busy = st != P_IDLE;
  // rs[1] is the synchronized line, rs[2] its previous value for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rs <= 3'b111;
      rx_st <= R_IDLE;
      rcnt <= '0;
      nb <= '0;
      rx_dat <= '0;
      rx_vld <= 1'b0;
      ferr <= 1'b0;
    end else begin
      rs <= {rs[1:0], rxd};
      rx_vld <= 1'b0;
      ferr <= 1'b0;
      rcnt <= rcnt + 16'd1;
      case (rx_st)
        R_IDLE: if (rs[2] && !rs[1]) begin rx_st <= R_START; rcnt <= '0; end
        R_START: if (rcnt == HALF) begin
          rcnt <= '0;
          nb <= '0;
          rx_st <= rs[1] ? R_IDLE : R_DATA;
        end
        R_DATA: if (rcnt == FULL) begin
          rcnt <= '0;
          rx_dat <= {rs[1], rx_dat[7:1]};
          nb <= nb + 3'd1;
          if (nb == 3'd7) rx_st <= R_STOP;
        end
        default: if (rcnt == FULL) begin
          rx_st <= R_IDLE;
          rx_vld <= rs[1];
          ferr <= !rs[1];
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      txd <= 1'b1;
      tx_busy <= 1'b0;
      tsh <= '0;
      tbc <= '0;
      tcnt <= '0;
    end else if (!tx_busy) begin
      if (tx_ld) begin
        tsh <= {1'b1, tx_dat};
        txd <= 1'b0;
        tx_busy <= 1'b1;
        tbc <= '0;
        tcnt <= '0;
      end
    end else if (tcnt == FULL) begin
      tcnt <= '0;
      tbc <= tbc + 4'd1;
      if (tbc == 4'd9) tx_busy <= 1'b0;
      else begin
        txd <= tsh[0];
        tsh <= {1'b1, tsh[8:1]};
      end
    end else tcnt <= tcnt + 16'd1;
  end
`ifdef RV_UBM_TIMEOUT_EN
  logic [31:0] to_cnt;
  always_ff @(posedge clk)
    to_cnt <= (rst || rx_vld || !(st == P_ADDR || st == P_DATA)) ? '0 : to_cnt + 32'd1;
  assign tout = to_cnt == 32'(TO_CYC);
`else
  assign tout = TO_CYC < 0;
`endif
  always_comb begin
    st_n = st;
    tx_ld = 1'b0;
    tx_dat = 8'h3F;
    case (st)
      P_IDLE: if (rx_vld) begin
        st_n = (rx_dat == 8'h57 || rx_dat == 8'h52) ? P_ADDR : P_IDLE;
        tx_ld = !(rx_dat == 8'h57 || rx_dat == 8'h52);
      end
      P_ADDR: if (rx_vld && cnt == 2'd3) st_n = is_w ? P_DATA : P_REQ;
      P_DATA: if (rx_vld && cnt == 2'd3) st_n = P_REQ;
      P_REQ: st_n = P_WAIT;
      P_WAIT: if (rdy) st_n = P_REPLY;
      P_REPLY: if (!cap && !tx_busy) begin
        tx_ld = 1'b1;
        tx_dat = is_w ? 8'h4B : rsh[31:24];
        if (is_w || cnt == 2'd3) st_n = P_IDLE;
      end
      default: st_n = P_IDLE;
    endcase
    if ((st == P_ADDR || st == P_DATA) && (ferr || tout)) st_n = P_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= P_IDLE;
      cnt <= '0;
      is_w <= 1'b0;
      cap <= 1'b0;
      abuf <= '0;
      rsh <= '0;
      adr <= '0;
      dw <= '0;
      cs <= 1'b0;
      we <= '0;
      re <= 1'b0;
    end else begin
      st <= st_n;
      case (st)
        P_IDLE: begin
          cnt <= '0;
          if (rx_vld) is_w <= rx_dat == 8'h57;
        end
        P_ADDR: if (rx_vld) begin abuf <= {abuf[23:0], rx_dat}; cnt <= cnt + 2'd1; end
        P_DATA: if (rx_vld) begin dw <= {dw[23:0], rx_dat}; cnt <= cnt + 2'd1; end
        P_REQ: begin
          cs <= 1'b1;
          adr <= {abuf[31:2], 2'b00};
          we <= is_w ? 4'hF : 4'h0;
          re <= !is_w;
        end
        P_WAIT: if (rdy) begin
          cs <= 1'b0;
          we <= '0;
          re <= 1'b0;
          cap <= 1'b1;
          cnt <= '0;
        end
        P_REPLY: if (cap) begin
          cap <= 1'b0;
          rsh <= dr;
        end else if (!tx_busy) begin
          rsh <= {rsh[23:0], 8'h00};
          cnt <= cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rv_uart_busmaster.sv
// tb_rv_uart_busmaster: directed frames from a host model; replies and bus cycles checked against expected queues.
module tb_rv_uart_busmaster;
  localparam int BD = 10;
  localparam int TO = 300;
  logic clk = 0, rst = 1, rxd = 1, rdy = 0;
  logic txd, cs, re, busy, ferr;
  logic [31:0] adr, dw, dr = 32'hCAFEF00D;
  logic [3:0] we;
  typedef struct {logic [31:0] adr; logic [3:0] we; logic re; logic [31:0] dw;} bus_t;
  bus_t bus_q[$], exp_bus[$];
  logic [7:0] rx_q[$], exp_rx[$];
  int checks = 0, errors = 0, cs_cyc = 0, ferr_cnt = 0, rdy_lat = 0, wc = 0, f0;
  bit hold = 0;

  rv_uart_busmaster #(.BAUD_DIV(BD), .TO_CYC(TO)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .txd(txd), .adr(adr), .cs(cs), .we(we),
    .re(re), .dw(dw), .dr(dr), .rdy(rdy), .busy(busy), .ferr(ferr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cs) cs_cyc++;
    if (cs && rdy) bus_q.push_back('{adr, we, re, dw});
    if (ferr) ferr_cnt++;
  end

  // bus target: rdy rises after rdy_lat cycles of cs unless held off
  initial forever begin
    @(posedge clk); #1;
    if (cs && !hold) begin rdy = wc >= rdy_lat; wc++; end
    else begin rdy = 0; wc = 0; end
  end

  // host receiver: samples txd mid-bit
  initial forever begin
    logic [7:0] b;
    @(negedge clk);
    if (txd === 1'b0) begin
      repeat (BD / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BD) @(negedge clk);
        b[i] = txd;
      end
      repeat (BD) @(negedge clk);
      rx_q.push_back(b);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s got=none exp=event", tag);
  endtask

  task automatic bit_out(input logic v);
    rxd = v;
    repeat (BD) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit bad = 0);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(!bad);
    if (bad) bit_out(1'b1);
  endtask

  task automatic send_w(input logic [31:0] a, input logic [31:0] d);
    exp_bus.push_back('{a & ~32'h3, 4'hF, 1'b0, d});
    exp_rx.push_back(8'h4B);
    send(8'h57);
    for (int i = 3; i >= 0; i--) send(a[8*i+:8]);
    for (int i = 3; i >= 0; i--) send(d[8*i+:8]);
  endtask

  task automatic send_r(input logic [31:0] a, input logic [31:0] d);
    dr = d;
    exp_bus.push_back('{a & ~32'h3, 4'h0, 1'b1, 32'h0});
    for (int i = 3; i >= 0; i--) exp_rx.push_back(d[8*i+:8]);
    send(8'h52);
    for (int i = 3; i >= 0; i--) send(a[8*i+:8]);
  endtask

  task automatic drain(input string tag);
    bus_t g, e;
    int t;
    while (exp_rx.size() > 0) begin
      t = 0;
      while (rx_q.size() == 0 && t < 3000) begin @(negedge clk); t++; end
      if (rx_q.size() == 0) begin fail({tag, "_reply_timeout"}); exp_rx.delete(); end
      else chk({tag, "_reply"}, 32'(rx_q.pop_front()), 32'(exp_rx.pop_front()));
    end
    while (exp_bus.size() > 0) begin
      e = exp_bus.pop_front();
      if (bus_q.size() == 0) fail({tag, "_bus_missing"});
      else begin
        g = bus_q.pop_front();
        chk({tag, "_adr"}, g.adr, e.adr);
        chk({tag, "_we"}, 32'(g.we), 32'(e.we));
        chk({tag, "_re"}, 32'(g.re), 32'(e.re));
        if (e.we != 4'h0) chk({tag, "_dw"}, g.dw, e.dw);
      end
    end
    repeat (3 * BD) @(negedge clk);
    chk({tag, "_extra_rx"}, rx_q.size(), 0);
    chk({tag, "_extra_bus"}, bus_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_txd", 32'(txd), 1);
    chk("rst_cs", 32'(cs), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_re", 32'(re), 0);
    chk("rst_adr", adr, 0);
    chk("rst_dw", dw, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ferr", 32'(ferr), 0);
    @(posedge clk); #1 rst = 0;
    repeat (5) @(posedge clk);
    #1;

    cs_cyc = 0; rdy_lat = 0;
    send_w(32'h0000_1000, 32'hDEAD_BEEF);
    drain("w1");
    chk("w1_cs_cycles", cs_cyc, 1);
    chk("w1_busy", 32'(busy), 0);

    cs_cyc = 0; rdy_lat = 5;
    send_r(32'h0000_1003, 32'hCAFE_F00D);
    drain("r1");
    chk("r1_cs_cycles", cs_cyc, 6);

    cs_cyc = 0;
    exp_rx.push_back(8'h3F);
    send(8'h41);
    drain("badcmd");
    chk("badcmd_cs_cycles", cs_cyc, 0);

    cs_cyc = 0; rdy_lat = 2;
    send_w(32'h0000_0010, 32'h1234_5678);
    drain("w2");
    chk("w2_cs_cycles", cs_cyc, 3);

    cs_cyc = 0; f0 = ferr_cnt;
    send(8'h57);
    send(8'h00);
    send(8'h00, 1);
    chk("ferr_pulse", ferr_cnt, f0 + 1);
    chk("ferr_busy", 32'(busy), 0);
    repeat (300) @(posedge clk);
    #1;
    chk("ferr_cs_cycles", cs_cyc, 0);
    chk("ferr_no_reply", rx_q.size(), 0);

    f0 = ferr_cnt;
    rxd = 0;
    @(posedge clk); #1 rxd = 1;
    repeat (300) @(posedge clk);
    #1;
    chk("glitch_busy", 32'(busy), 0);
    chk("glitch_no_reply", rx_q.size(), 0);
    chk("glitch_no_ferr", ferr_cnt, f0);

    hold = 1;
    send(8'h52);
    for (int i = 0; i < 4; i++) send(8'h20);
    t = 0;
    while (!cs && t < 500) begin @(posedge clk); #1; t++; end
    chk("rstwait_cs_up", 32'(cs), 1);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rstwait_cs", 32'(cs), 0);
    chk("rstwait_re", 32'(re), 0);
    chk("rstwait_txd", 32'(txd), 1);
    chk("rstwait_busy", 32'(busy), 0);
    chk("rstwait_adr", adr, 0);
    hold = 0;
    repeat (300) @(posedge clk);
    #1;
    chk("rstwait_no_bus", bus_q.size(), 0);
    chk("rstwait_no_reply", rx_q.size(), 0);

    cs_cyc = 0; rdy_lat = 0;
    send(8'h57);
    send(8'h00);
    send(8'h00);
    repeat (TO + 50) @(posedge clk);
    #1;
`ifdef RV_UBM_TIMEOUT_EN
    chk("timeout_busy", 32'(busy), 0);
    chk("timeout_no_reply", rx_q.size(), 0);
    chk("timeout_cs_cycles", cs_cyc, 0);
`else
    chk("partial_busy", 32'(busy), 1);
    exp_bus.push_back('{32'h0000_0004, 4'hF, 1'b0, 32'hA5A5_5A5A});
    exp_rx.push_back(8'h4B);
    send(8'h00);
    send(8'h04);
    send(8'hA5); send(8'hA5); send(8'h5A); send(8'h5A);
    drain("partial");
    chk("partial_cs_cycles", cs_cyc, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
